// File: rtl/ysyx_25020037_lsu.sv
// Load/store unit: one op per handshake, one word-aligned memory request, aligned/extended result to writeback.
// Optional build macro YSYX_25020037_LSU_MISALIGN_EN: misaligned half/word accesses complete at once with lsu_exc=1.
module ysyx_25020037_lsu #(
    parameter int PASS_WD = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               exu_valid,
    output logic               lsu_ready,
    input  logic               lsu_ld,
    input  logic               lsu_st,
    input  logic [1:0]         lsu_size,
    input  logic               lsu_unsigned,
    input  logic [31:0]        lsu_addr,
    input  logic [31:0]        lsu_wdata,
    input  logic [PASS_WD-1:0] lsu_pass,
    output logic               mem_req_valid,
    input  logic               mem_req_ready,
    output logic               mem_req_we,
    output logic [31:0]        mem_req_addr,
    output logic [31:0]        mem_req_wdata,
    output logic [3:0]         mem_req_wstrb,
    input  logic               mem_rsp_valid,
    input  logic [31:0]        mem_rsp_rdata,
    input  logic               wbu_ready,
    output logic               lsu_valid,
    output logic [31:0]        lsu_result,
    output logic [PASS_WD-1:0] lsu_pass_out,
    output logic [31:0]        rdata_processed,
    output logic               lsu_exc
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } state_e;

    state_e             state_q;
    logic               ld_q;
    logic               st_q;
    logic               uns_q;
    logic [1:0]         size_q;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic [PASS_WD-1:0] pass_q;

    logic               valid_q;
    logic               exc_q;
    logic [31:0]        result_q;
    logic [31:0]        rdp_q;
    logic [PASS_WD-1:0] pass_out_q;

    logic               accept;
    logic               mem_op_in;
    logic               misalign_in;
    logic               mem_done;
    logic [31:0]        load_d;

    function automatic logic [31:0] st_align(input logic [31:0] d, input logic [1:0] sz);
        case (sz)
            2'd0:    st_align = {4{d[7:0]}};
            2'd1:    st_align = {2{d[15:0]}};
            default: st_align = d;
        endcase
    endfunction

    function automatic logic [3:0] st_strb(input logic [1:0] off, input logic [1:0] sz);
        case (sz)
            2'd0:    st_strb = 4'b0001 << off;
            2'd1:    st_strb = 4'b0011 << {off[1], 1'b0};
            default: st_strb = 4'b1111;
        endcase
    endfunction

    // Lanes shifted past byte 3 fill with zero before extension.
    function automatic logic [31:0] ld_fmt(input logic [31:0] rdata, input logic [1:0] off,
                                           input logic [1:0] sz, input logic uns);
        logic [31:0] sh;
        sh = rdata >> {off, 3'b000};
        case (sz)
            2'd0:    ld_fmt = uns ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            2'd1:    ld_fmt = uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: ld_fmt = sh;
        endcase
    endfunction

`ifdef YSYX_25020037_LSU_MISALIGN_EN
    function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = (off == 2'd3);
            default: misaligned = (off != 2'd0);
        endcase
    endfunction

    assign misalign_in = mem_op_in && misaligned(lsu_size, lsu_addr[1:0]);
`else
    assign misalign_in = 1'b0;
`endif

    assign lsu_ready = (state_q == IDLE) && (!valid_q || wbu_ready);
    assign accept    = exu_valid && lsu_ready;
    assign mem_op_in = lsu_ld || lsu_st;

    // A response only counts once the request has been (or is being) accepted.
    assign mem_done = ((state_q == REQ) && mem_req_ready && mem_rsp_valid) ||
                      ((state_q == RSP) && mem_rsp_valid);
    assign load_d   = ld_fmt(mem_rsp_rdata, addr_q[1:0], size_q, uns_q);

    assign mem_req_valid = (state_q == REQ);
    assign mem_req_we    = st_q;
    assign mem_req_addr  = {addr_q[31:2], 2'b00};
    assign mem_req_wdata = st_q ? st_align(wdata_q, size_q) : 32'd0;
    assign mem_req_wstrb = st_q ? st_strb(addr_q[1:0], size_q) : 4'd0;

    assign lsu_valid       = valid_q;
    assign lsu_result      = result_q;
    assign lsu_pass_out    = pass_out_q;
    assign rdata_processed = rdp_q;
    assign lsu_exc         = exc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ld_q       <= 1'b0;
            st_q       <= 1'b0;
            uns_q      <= 1'b0;
            size_q     <= 2'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            pass_q     <= '0;
            valid_q    <= 1'b0;
            exc_q      <= 1'b0;
            result_q   <= 32'd0;
            rdp_q      <= 32'd0;
            pass_out_q <= '0;
        end else begin
            if (wbu_ready) begin
                valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (accept) begin
                        ld_q    <= lsu_ld;
                        st_q    <= lsu_st;
                        uns_q   <= lsu_unsigned;
                        size_q  <= lsu_size;
                        addr_q  <= lsu_addr;
                        wdata_q <= lsu_wdata;
                        pass_q  <= lsu_pass;
                        if (!mem_op_in || misalign_in) begin
                            valid_q    <= 1'b1;
                            result_q   <= lsu_addr;
                            pass_out_q <= lsu_pass;
                            exc_q      <= misalign_in;
                        end else begin
                            state_q <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        state_q <= mem_rsp_valid ? IDLE : RSP;
                    end
                end
                RSP: begin
                    if (mem_rsp_valid) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (mem_done) begin
                valid_q    <= 1'b1;
                exc_q      <= 1'b0;
                pass_out_q <= pass_q;
                if (ld_q) begin
                    result_q <= load_d;
                    rdp_q    <= load_d;
                end else begin
                    result_q <= addr_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_ysyx_25020037_lsu.sv
// Randomized self-checking bench for ysyx_25020037_lsu against a byte-level reference model.
module tb_ysyx_25020037_lsu;
    localparam int PASS_WD = 64;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               exu_valid = 1'b0;
    logic               lsu_ready;
    logic               lsu_ld = 1'b0;
    logic               lsu_st = 1'b0;
    logic [1:0]         lsu_size = 2'd0;
    logic               lsu_unsigned = 1'b0;
    logic [31:0]        lsu_addr = 32'd0;
    logic [31:0]        lsu_wdata = 32'd0;
    logic [PASS_WD-1:0] lsu_pass = '0;
    logic               mem_req_valid;
    logic               mem_req_ready = 1'b0;
    logic               mem_req_we;
    logic [31:0]        mem_req_addr;
    logic [31:0]        mem_req_wdata;
    logic [3:0]         mem_req_wstrb;
    logic               mem_rsp_valid = 1'b0;
    logic [31:0]        mem_rsp_rdata = 32'd0;
    logic               wbu_ready = 1'b1;
    logic               lsu_valid;
    logic [31:0]        lsu_result;
    logic [PASS_WD-1:0] lsu_pass_out;
    logic [31:0]        rdata_processed;
    logic               lsu_exc;

    ysyx_25020037_lsu #(.PASS_WD(PASS_WD)) dut (
        .clk(clk), .rst(rst),
        .exu_valid(exu_valid), .lsu_ready(lsu_ready),
        .lsu_ld(lsu_ld), .lsu_st(lsu_st), .lsu_size(lsu_size), .lsu_unsigned(lsu_unsigned),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_pass(lsu_pass),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
        .wbu_ready(wbu_ready), .lsu_valid(lsu_valid), .lsu_result(lsu_result),
        .lsu_pass_out(lsu_pass_out), .rdata_processed(rdata_processed), .lsu_exc(lsu_exc)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_rdp = 32'd0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    // An access is misaligned when it would spill past the end of its word.
    function automatic bit is_mis(input logic [1:0] sz, input logic [31:0] a);
`ifdef YSYX_25020037_LSU_MISALIGN_EN
        return (int'(a % 4) + nbytes(sz)) > 4;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] rd, input logic [31:0] a,
                                             input logic [1:0] sz, input bit uns);
        int          n = nbytes(sz);
        int          off = int'(a % 4);
        logic [31:0] v = 32'd0;
        for (int i = 0; i < n; i++)
            if (off + i < 4) v = v | (((rd >> (8 * (off + i))) & 32'hFF) << (8 * i));
        if (n < 4 && !uns && v[8 * n - 1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        return v;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [31:0] wd, input logic [1:0] sz);
        int          n = nbytes(sz);
        logic [31:0] v = 32'd0;
        for (int i = 0; i < 4; i++) v = v | (((wd >> (8 * (i % n))) & 32'hFF) << (8 * i));
        return v;
    endfunction

    function automatic logic [3:0] exp_strb(input logic [31:0] a, input logic [1:0] sz);
        int         n = nbytes(sz);
        int         start = (sz == 2'd0) ? int'(a % 4) : (sz == 2'd1) ? int'(a % 4) & 2 : 0;
        logic [3:0] s = 4'd0;
        for (int i = 0; i < 4; i++) if (i >= start && i < start + n) s[i] = 1'b1;
        return s;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            mem_rsp_valid = 1'($urandom % 2);
            mem_rsp_rdata = $urandom;
            @(negedge clk);
            mem_rsp_valid = 1'b0;
            check("idle_valid", lsu_valid, 0);
            check("idle_rdp", rdata_processed, exp_rdp);
        end
    endtask

    task automatic do_op(input bit ld, input bit st, input logic [1:0] sz, input bit uns,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                         input logic [63:0] ps, input int req_dly, input int rsp_dly,
                         input int wb_stall, input bit same);
        bit          mis = (ld || st) && is_mis(sz, a);
        bit          mem = (ld || st) && !mis;
        logic [31:0] exp_res;
        int          n = 0;
        while (!lsu_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", lsu_ready, 1);
        exu_valid = 1'b1; lsu_ld = ld; lsu_st = st; lsu_size = sz; lsu_unsigned = uns;
        lsu_addr = a; lsu_wdata = wd; lsu_pass = ps; wbu_ready = 1'b1;
        @(negedge clk);
        exu_valid = 1'b0; lsu_ld = 1'b0; lsu_st = 1'b0; lsu_size = 2'($urandom);
        lsu_addr = $urandom; lsu_wdata = $urandom; lsu_pass = {$urandom, $urandom};
        if (!mem) begin
            check("fast_valid", lsu_valid, 1);
            check("fast_result", lsu_result, a);
            check("fast_pass", lsu_pass_out, ps);
            check("fast_exc", lsu_exc, mis);
            check("fast_noreq", mem_req_valid, 0);
        end else begin
            check("mem_accept_valid", lsu_valid, 0);
            for (int i = 0; i <= req_dly; i++) begin
                check("req_valid", mem_req_valid, 1);
                check("req_addr", mem_req_addr, a & ~32'd3);
                check("req_we", mem_req_we, st);
                check("req_wstrb", mem_req_wstrb, st ? exp_strb(a, sz) : 4'd0);
                if (st) check("req_wdata", mem_req_wdata, exp_wdata(wd, sz));
                check("req_busy", lsu_ready, 0);
                if (i < req_dly) begin
                    mem_rsp_valid = 1'($urandom % 2);
                    mem_rsp_rdata = $urandom;
                    @(negedge clk);
                    mem_rsp_valid = 1'b0;
                end
            end
            mem_req_ready = 1'b1;
            if (same) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_rdata = rd;
            end
            @(negedge clk);
            mem_req_ready = 1'b0;
            mem_rsp_valid = 1'b0;
            if (!same) begin
                for (int i = 0; i < rsp_dly; i++) begin
                    check("rsp_wait_valid", lsu_valid, 0);
                    check("rsp_wait_req", mem_req_valid, 0);
                    @(negedge clk);
                end
                mem_rsp_valid = 1'b1;
                mem_rsp_rdata = rd;
                @(negedge clk);
                mem_rsp_valid = 1'b0;
            end
            exp_res = ld ? exp_load(rd, a, sz, uns) : a;
            if (ld) exp_rdp = exp_res;
            check("done_valid", lsu_valid, 1);
            check("done_result", lsu_result, exp_res);
            check("done_pass", lsu_pass_out, ps);
            check("done_exc", lsu_exc, 0);
        end
        check("rdp", rdata_processed, exp_rdp);
        if (wb_stall > 0) begin
            exp_res = lsu_result;
            wbu_ready = 1'b0;
            for (int i = 0; i < wb_stall; i++) begin
                @(negedge clk);
                check("hold_valid", lsu_valid, 1);
                check("hold_result", lsu_result, exp_res);
                check("hold_pass", lsu_pass_out, ps);
                check("hold_exc", lsu_exc, mis);
                check("hold_ready", lsu_ready, 0);
            end
            wbu_ready = 1'b1;
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_valid", lsu_valid, 0);
        check("rst_result", lsu_result, 0);
        check("rst_req", mem_req_valid, 0);
        check("rst_rdp", rdata_processed, 0);
        check("rst_exc", lsu_exc, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", lsu_ready, 1);

        do_op(0, 0, 2'd2, 0, 32'h1234, 32'h0, 32'h0, 64'hAA55, 0, 0, 0, 0);
        do_op(1, 0, 2'd0, 0, 32'h80000003, 32'h0, 32'h80FFFF00, 64'h1, 1, 1, 0, 0);
        check("lb_const", lsu_result, 32'hFFFFFF80);
        check("lb_rdp_const", rdata_processed, 32'hFFFFFF80);
        do_op(1, 0, 2'd0, 1, 32'h80000003, 32'h0, 32'h80FFFF00, 64'h2, 0, 0, 0, 1);
        check("lbu_const", lsu_result, 32'h00000080);
        do_op(0, 1, 2'd1, 0, 32'h80000002, 32'hABCD1234, 32'h0, 64'h3, 5, 2, 0, 0);
        check("sh_rdp_hold", rdata_processed, 32'h00000080);
        do_op(1, 0, 2'd1, 0, 32'h80000000, 32'h0, 32'h00008001, 64'h4, 0, 1, 3, 0);
        do_op(0, 0, 2'd0, 0, 32'hCAFE0000, 32'h0, 32'h0, 64'h5, 0, 0, 0, 0);
        do_op(1, 0, 2'd2, 0, 32'h80000002, 32'h0, 32'h11223344, 64'h6, 0, 0, 0, 0);
`ifdef YSYX_25020037_LSU_MISALIGN_EN
        check("mis_exc", lsu_exc, 1);
`endif
        idle(2);

        // Reset while the load is waiting for its response; the late response must be dropped.
        lsu_ld = 1'b1; lsu_size = 2'd2; lsu_addr = 32'h80000010; exu_valid = 1'b1;
        @(negedge clk);
        exu_valid = 1'b0; lsu_ld = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        check("rsp_state_req", mem_req_valid, 0);
        #2 rst = 1'b1;
        #1;
        check("midrst_valid", lsu_valid, 0);
        check("midrst_result", lsu_result, 0);
        check("midrst_rdp", rdata_processed, 0);
        check("midrst_req", mem_req_valid, 0);
        exp_rdp = 32'd0;
        @(negedge clk);
        rst = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'hDEADBEEF;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        check("stale_valid", lsu_valid, 0);
        check("stale_rdp", rdata_processed, 0);
        check("stale_ready", lsu_ready, 1);

        for (int k = 0; k < 300; k++) begin
            int          kind = int'($urandom_range(0, 2));
            logic [31:0] a = $urandom;
            do_op(kind == 1, kind == 2, 2'($urandom), 1'($urandom % 2), a, $urandom, $urandom,
                  {$urandom, $urandom}, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 2)), 1'($urandom % 2));
            if ($urandom_range(0, 7) == 0) idle(int'($urandom_range(1, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got=%0d exp=%0d", total, 0);
        $fatal(1);
    end
endmodule
